// File: rtl/ps2_mouse_init_if.sv
// Byte-level handshake between the mouse init sequencer and the PS/2 transmitter/receiver.
interface ps2_mouse_init_if;
    logic       tx_idle;
    logic       tx_done_tick;
    logic       rx_done_tick;
    logic [7:0] rx_dout;
    logic       wr_ps2;
    logic [7:0] din;
    logic       rx_en;

    modport master (
        input  tx_idle, tx_done_tick, rx_done_tick, rx_dout,
        output wr_ps2, din, rx_en
    );

    modport slave (
        output tx_idle, tx_done_tick, rx_done_tick, rx_dout,
        input  wr_ps2, din, rx_en
    );
endinterface

// File: rtl/ps2_mouse_init.sv
// Drives a PS/2 mouse through reset (FF), BAT/ID check and enable-streaming (F4),
// restarting the whole sequence on a bad byte or a per-step timeout.
module ps2_mouse_init #(
    parameter int TIMEOUT_CYC = 25_000_000,
    parameter int MAX_RETRY   = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    ps2_mouse_init_if.master     ps2,
    output logic                 busy,
    output logic                 init_done,
    output logic                 init_err,
    output logic [1:0]           retry_cnt
);

    typedef enum logic [3:0] {
        RST_SEND, RST_TXW, ACK1, BAT, ID, EN_SEND, EN_TXW, ACK2, DONE, FAIL
    } state_t;

    localparam logic [24:0] TIMEOUT_LAST = 25'(TIMEOUT_CYC - 1);

    state_t      state_q, state_d;
    logic [24:0] cnt_q, cnt_d;
    logic [1:0]  retry_q, retry_d;
    logic        wr_q, wr_d;
    logic [7:0]  din_q, din_d;
    logic        rx_en_q, busy_q, done_q, err_q;
    logic        timeout, fail;

    function automatic logic [7:0] expected_byte(state_t s);
        case (s)
            BAT:     return 8'hAA;
            ID:      return 8'h00;
            default: return 8'hFA;
        endcase
    endfunction

    assign timeout = (cnt_q == TIMEOUT_LAST);

    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        wr_d    = 1'b0;
        din_d   = din_q;
        fail    = 1'b0;
        case (state_q)
            RST_SEND, EN_SEND: begin
                if (ps2.tx_idle) begin
                    wr_d    = 1'b1;
                    din_d   = (state_q == RST_SEND) ? 8'hFF : 8'hF4;
                    state_d = (state_q == RST_SEND) ? RST_TXW : EN_TXW;
                end else if (timeout) begin
                    fail = 1'b1;
                end
            end
            RST_TXW, EN_TXW: begin
                if (ps2.tx_done_tick)
                    state_d = (state_q == RST_TXW) ? ACK1 : ACK2;
                else if (timeout)
                    fail = 1'b1;
            end
            // A received byte wins over a timeout landing on the same cycle.
            ACK1, BAT, ID, ACK2: begin
                if (ps2.rx_done_tick) begin
                    if (ps2.rx_dout != expected_byte(state_q))
                        fail = 1'b1;
                    else if (state_q == ACK1)
                        state_d = BAT;
                    else if (state_q == BAT)
                        state_d = ID;
                    else if (state_q == ID)
                        state_d = EN_SEND;
                    else
                        state_d = DONE;
                end else if (timeout) begin
                    fail = 1'b1;
                end
            end
            default: begin
                if (start) begin
                    retry_d = 2'd0;
                    state_d = RST_SEND;
                end
            end
        endcase

        if (fail) begin
            if (int'(retry_q) < MAX_RETRY) begin
                retry_d = (retry_q == 2'd3) ? retry_q : retry_q + 2'd1;
                state_d = RST_SEND;
            end else begin
                state_d = FAIL;
            end
        end

        if (fail || state_d != state_q)
            cnt_d = '0;
        else if (state_q == DONE || state_q == FAIL)
            cnt_d = cnt_q;
        else
            cnt_d = cnt_q + 25'd1;
    end

    // Status outputs are decoded from the next state so they line up with state_q.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RST_SEND;
            cnt_q   <= '0;
            retry_q <= 2'd0;
            wr_q    <= 1'b0;
            din_q   <= 8'h00;
            rx_en_q <= 1'b0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            retry_q <= retry_d;
            wr_q    <= wr_d;
            din_q   <= din_d;
            rx_en_q <= (state_d inside {ACK1, BAT, ID, ACK2});
            busy_q  <= !(state_d inside {DONE, FAIL});
            done_q  <= (state_d == DONE);
            err_q   <= (state_d == FAIL);
        end
    end

    assign ps2.wr_ps2 = wr_q;
    assign ps2.din    = din_q;
    assign ps2.rx_en  = rx_en_q;
    assign busy       = busy_q;
    assign init_done  = done_q;
    assign init_err   = err_q;
    assign retry_cnt  = retry_q;

endmodule

// File: doc/ps2_mouse_init.md
PS2_MOUSE_INIT -- requirements
Module: ps2_mouse_init

Interface
REQ-001 Parameter TIMEOUT_CYC, default 25_000_000, sets per-step timeout in clk cycles (500 ms at 50 MHz).
REQ-002 Parameter MAX_RETRY, default 3, sets the number of full-sequence restarts allowed before failure.
REQ-003 Port clk, input, 1 bit: system clock; all logic on its rising edge.
REQ-004 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 Port start, input, 1 bit: one-cycle request to rerun the sequence; honoured only in DONE or FAIL.
REQ-006 Port tx_idle, input, 1 bit: PS/2 transmitter ready.
REQ-007 Port tx_done_tick, input, 1 bit: transmitter finished a byte.
REQ-008 Port rx_done_tick, input, 1 bit: receiver produced a byte.
REQ-009 Port rx_dout, input, 8 bits: received byte, valid when rx_done_tick=1.
REQ-010 Port wr_ps2, output, 1 bit: one-cycle transmit strobe.
REQ-011 Port din, output, 8 bits: command byte to transmitter.
REQ-012 Port rx_en, output, 1 bit: receiver enable.
REQ-013 Port busy, output, 1 bit: sequence in progress.
REQ-014 Port init_done, output, 1 bit: mouse in stream mode.
REQ-015 Port init_err, output, 1 bit: sequence failed.
REQ-016 Port retry_cnt, output, 2 bits: restarts consumed.

Function
REQ-017 States, in order: RST_SEND, RST_TXW, ACK1, BAT, ID, EN_SEND, EN_TXW, ACK2, DONE, FAIL.
REQ-018 In RST_SEND, when tx_idle=1, wr_ps2 SHALL pulse for exactly 1 cycle with din=8'hFF, then the block SHALL enter RST_TXW.
REQ-019 In RST_TXW, tx_done_tick SHALL move the block to ACK1.
REQ-020 In ACK1, BAT and ID, the block SHALL wait for rx_done_tick and compare rx_dout against 8'hFA, 8'hAA and 8'h00 respectively; a match SHALL advance to the next state.
REQ-021 In EN_SEND, when tx_idle=1, wr_ps2 SHALL pulse for 1 cycle with din=8'hF4, then the block SHALL enter EN_TXW.
REQ-022 In EN_TXW, tx_done_tick SHALL move the block to ACK2; in ACK2, 8'hFA SHALL move it to DONE.
REQ-023 din SHALL hold the current command byte from the strobe cycle until the matching tx_done_tick.
REQ-024 rx_en SHALL be 1 only in ACK1, BAT, ID and ACK2, and 0 in every other state.
REQ-025 Timeout counter: 25-bit, cleared on every state change, incremented each cycle in all states except DONE and FAIL.
REQ-026 A timeout occurs when the counter reaches TIMEOUT_CYC-1.
REQ-027 Mismatched byte, 8'hFE (resend) or timeout: if retry_cnt < MAX_RETRY, the block SHALL increment retry_cnt and restart at RST_SEND; otherwise it SHALL enter FAIL.
REQ-028 Simultaneous rx_done_tick and timeout: the received byte takes priority; no timeout is taken that cycle.
REQ-029 A tx_done_tick outside RST_TXW/EN_TXW and an rx_done_tick outside a wait state SHALL be ignored.
REQ-030 busy SHALL be 1 in all states except DONE and FAIL.
REQ-031 init_done SHALL be 1 only in DONE; init_err SHALL be 1 only in FAIL; both are registered.
REQ-032 start in DONE or FAIL SHALL clear retry_cnt and enter RST_SEND on the next cycle; start in any other state SHALL be ignored.
REQ-033 retry_cnt SHALL saturate and never wrap.

Reset
REQ-034 While reset=1 at a clk edge: state=RST_SEND, counter=0, retry_cnt=0, wr_ps2=0, din=8'h00, rx_en=0, busy=1, init_done=0, init_err=0.
REQ-035 Reset mid-sequence SHALL abort without any further wr_ps2 pulse.
REQ-036 After reset is released, the sequence SHALL start automatically.
REQ-037 Reset SHALL override start and all other inputs.

Verification
REQ-038 Nominal case: tx_idle=1, ticks provided, bytes FA, AA, 00, FA returned -> exactly two wr_ps2 pulses (din FF then F4); init_done=1, retry_cnt=0.
REQ-039 Stall case: tx_idle=0 for 100 cycles -> no wr_ps2 until tx_idle=1, then a single 1-cycle pulse.
REQ-040 Mismatch case: BAT returns 8'hFC -> retry_cnt=1, wr_ps2 with din=FF again; nominal bytes afterwards -> DONE.
REQ-041 Silent device, TIMEOUT_CYC=16: no rx bytes -> 3 restarts, then FAIL with init_err=1, busy=0, retry_cnt=3.
REQ-042 Start/priority case: start pulsed in FAIL -> retry_cnt=0 and sequence reruns; start pulsed while busy -> no effect; rx_done_tick with FA on the timeout cycle in ACK1 -> advance to BAT.
REQ-043 Reset case: reset asserted in ID -> outputs at reset values next cycle; after release, din=FF strobe once tx_idle=1.
